// File: rtl/sparc_rf_pkg.sv
// Shared constants and types for the SPARC windowed register file.
//   NGLOBALS    : number of global registers (r0..r7), shared by all windows
//   WIN_REGS    : registers each window adds to the physical array (locals + ins)
//   rf_addr_t   : 5-bit logical register address (r0..r31)
//   phys_count  : size of the physical array for a given window count
package sparc_rf_pkg;
  localparam int NGLOBALS   = 8;
  localparam int WIN_REGS   = 16;
  localparam int LOG_ADDR_W = 5;

  typedef logic [LOG_ADDR_W-1:0] rf_addr_t;

  function automatic int phys_count(input int nwindows);
    return NGLOBALS + WIN_REGS * nwindows;
  endfunction
endpackage

// File: rtl/windowed_register_file_if.sv
// Register-file access bus: three read selects with their data and one write port.
// This bus has no valid/ready handshake. Reads are combinational and always
// valid for the current selects. A write is accepted at every rising clock
// edge where LE is high. There is no backpressure.
//   master : drives RA/RB/RC/RW/PW/LE, receives PA/PB/PD (decode/writeback side)
//   slave  : the register file
interface windowed_register_file_if
  import sparc_rf_pkg::*;
#(
  parameter int DATA_W = 32
);
  rf_addr_t          RA, RB, RC, RW;
  logic [DATA_W-1:0] PA, PB, PD, PW;
  logic              LE;

  modport master (output RA, RB, RC, RW, PW, LE, input PA, PB, PD);
  modport slave  (input RA, RB, RC, RW, PW, LE, output PA, PB, PD);
endinterface

// File: rtl/rf_addr_map.sv
// Logical-to-physical register index translation.
//   addr : logical register r0..r31
//   cwp  : current window pointer
//   phys : index into the physical array
// Globals map straight through. Windowed registers sit at 8 + (cwp*16 + addr-8)
// modulo 16*NWINDOWS. Because NWINDOWS is a power of two, the modulo is a plain
// truncation. This truncation makes window w's outs (r8..r15) land on window w-1's
// ins (r24..r31).
module rf_addr_map
  import sparc_rf_pkg::*;
#(
  parameter int NWINDOWS = 4,
  parameter int CWP_W    = 5,
  parameter int PHYS_W   = 7
) (
  input  rf_addr_t          addr,
  input  logic [CWP_W-1:0]  cwp,
  output logic [PHYS_W-1:0] phys
);
  localparam int WIN_BITS = $clog2(WIN_REGS * NWINDOWS);

  logic [WIN_BITS-1:0] wrapped;

  always_comb begin
    wrapped = WIN_BITS'({cwp, 4'b0000}) + WIN_BITS'(addr - 5'd8);
    if (addr < 5'd8) phys = PHYS_W'(addr);
    else             phys = PHYS_W'(NGLOBALS) + PHYS_W'(wrapped);
  end
endmodule

// File: rtl/windowed_register_file.sv
// SPARC windowed integer register file: 3 combinational read ports, 1 write port,
// SAVE/RESTORE window moves checked against the window invalid mask.
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   rf (slave)         : RA/RB/RC -> PA/PB/PD reads, RW/PW/LE write
//   save, restore      : window move requests (both together = no-op)
//   wim_we, wim_d      : load the window invalid mask
//   cwp, wim           : current window pointer and mask
//   win_ovf, win_unf   : registered one-cycle trap pulses
// Optional feature macro: RF_BYPASS_EN. When it is defined, a read port that
// selects the register being written in the same cycle returns PW directly.
module windowed_register_file
  import sparc_rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NWINDOWS = 4,
  parameter int CWP_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  windowed_register_file_if.slave rf,
  input  logic                save,
  input  logic                restore,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_d,
  output logic [CWP_W-1:0]    cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                win_ovf,
  output logic                win_unf
);
  localparam int PHYS_N    = phys_count(NWINDOWS);
  localparam int PHYS_W    = $clog2(PHYS_N);
  localparam int WIN_IDX_W = $clog2(NWINDOWS);

  logic [DATA_W-1:0]    regs_q [PHYS_N];
  logic [DATA_W-1:0]    regs_d [PHYS_N];
  logic [CWP_W-1:0]     cwp_q, cwp_d;
  logic [NWINDOWS-1:0]  mask_q, mask_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  logic [PHYS_W-1:0]    ra_phys, rb_phys, rc_phys, rw_phys;
  logic [WIN_IDX_W-1:0] cur_win, win_dn, win_up;
  logic                 wr_en;

  rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W))
    u_map_a (.addr(rf.RA), .cwp(cwp_q), .phys(ra_phys));
  rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W))
    u_map_b (.addr(rf.RB), .cwp(cwp_q), .phys(rb_phys));
  rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W))
    u_map_c (.addr(rf.RC), .cwp(cwp_q), .phys(rc_phys));
  rf_addr_map #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W), .PHYS_W(PHYS_W))
    u_map_w (.addr(rf.RW), .cwp(cwp_q), .phys(rw_phys));

  always_comb begin
    // The window index is kept in WIN_IDX_W bits, so +/-1 wraps mod NWINDOWS.
    cur_win = cwp_q[WIN_IDX_W-1:0];
    win_dn  = cur_win - WIN_IDX_W'(1);
    win_up  = cur_win + WIN_IDX_W'(1);
    wr_en   = rf.LE && (rf.RW != '0);

    // The write address was mapped with the pre-edge CWP, so a write issued
    // together with a window move lands in the old window.
    regs_d = regs_q;
    if (wr_en) regs_d[rw_phys] = rf.PW;

    cwp_d  = cwp_q;
    mask_d = wim_we ? wim_d : mask_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    // The mask test uses mask_q, which is the WIM value held before this edge.
    if (save && !restore) begin
      if (mask_q[win_dn]) ovf_d = 1'b1;
      else                cwp_d = CWP_W'(win_dn);
    end else if (restore && !save) begin
      if (mask_q[win_up]) unf_d = 1'b1;
      else                cwp_d = CWP_W'(win_up);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHYS_N; i++) regs_q[i] <= '0;
      cwp_q  <= '0;
      mask_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cwp_q  <= cwp_d;
      mask_q <= mask_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_comb begin
    rf.PA = (rf.RA == '0) ? '0 : regs_q[ra_phys];
    rf.PB = (rf.RB == '0) ? '0 : regs_q[rb_phys];
    rf.PD = (rf.RC == '0) ? '0 : regs_q[rc_phys];
`ifdef RF_BYPASS_EN
    // wr_en already excludes RW=0, so r0 can never be bypassed.
    if (wr_en && rf.RW == rf.RA && rw_phys == ra_phys) rf.PA = rf.PW;
    if (wr_en && rf.RW == rf.RB && rw_phys == rb_phys) rf.PB = rf.PW;
    if (wr_en && rf.RW == rf.RC && rw_phys == rc_phys) rf.PD = rf.PW;
`endif
  end

  assign cwp     = cwp_q;
  assign wim     = mask_q;
  assign win_ovf = ovf_q;
  assign win_unf = unf_q;
endmodule
